gray_ptr_ctrl: RTL and testbench

//  Pointer controller for one side of an async FIFO.

---
 rtl/cdc_pkg.sv | 24 ++
 rtl/gray2bin_pipe.sv | 64 ++++++
 rtl/gray_ptr_ctrl.sv | 113 +++++++++++
 tb/tb_gray_ptr_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared types and Gray/binary helpers for the async-FIFO pointer logic.
// The helpers work on a fixed 32-bit width. Narrower values are zero-extended into them.
package cdc_pkg;

    typedef enum logic {SIDE_RD, SIDE_WR} ptr_side_e;

    localparam int unsigned MAX_CONV_STAGES = 2;
    localparam int unsigned CDC_MAX_WIDTH   = 32;

    function automatic logic [CDC_MAX_WIDTH-1:0] bin2gray(input logic [CDC_MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // XOR-prefix from the MSB. Zero-extended upper bits leave the lower result untouched.
    function automatic logic [CDC_MAX_WIDTH-1:0] gray2bin(input logic [CDC_MAX_WIDTH-1:0] g);
        logic [CDC_MAX_WIDTH-1:0] b;
        b[CDC_MAX_WIDTH-1] = g[CDC_MAX_WIDTH-1];
        for (int i = CDC_MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_pipe.sv
// Gray-to-binary converter with 0..2 register stages; the two-stage form splits the
// XOR prefix chain between the upper and lower halves of the word.
module gray2bin_pipe
    import cdc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned STAGES     = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] gray_i,
    output logic [DATA_WIDTH-1:0] bin_o
);

    if (STAGES == 0) begin : g_comb
        assign bin_o = DATA_WIDTH'(gray2bin(CDC_MAX_WIDTH'(gray_i)));
    end else if (STAGES == 1) begin : g_one
        logic [DATA_WIDTH-1:0] bin_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                bin_q <= '0;
            end else begin
                bin_q <= DATA_WIDTH'(gray2bin(CDC_MAX_WIDTH'(gray_i)));
            end
        end
        assign bin_o = bin_q;
    end else begin : g_two
        localparam int Lo = int'(DATA_WIDTH / 2);
        localparam int Hi = int'(DATA_WIDTH) - Lo;

        logic [Hi-1:0]         hi_d, hi_q;
        logic [Lo-1:0]         lo_q, lo_bin;
        logic [DATA_WIDTH-1:0] bin_q;

        // Stage 1 resolves the upper half and carries the lower Gray bits forward.
        always_comb begin
            hi_d[Hi-1] = gray_i[DATA_WIDTH-1];
            for (int i = Hi - 2; i >= 0; i--) begin
                hi_d[i] = hi_d[i+1] ^ gray_i[i+Lo];
            end
        end

        always_comb begin
            lo_bin[Lo-1] = hi_q[0] ^ lo_q[Lo-1];
            for (int i = Lo - 2; i >= 0; i--) begin
                lo_bin[i] = lo_bin[i+1] ^ lo_q[i];
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                hi_q  <= '0;
                lo_q  <= '0;
                bin_q <= '0;
            end else begin
                hi_q  <= hi_d;
                lo_q  <= gray_i[Lo-1:0];
                bin_q <= {hi_q, lo_bin};
            end
        end
        assign bin_o = bin_q;
    end

endmodule

// File: rtl/gray_ptr_ctrl.sv
// One side of an async FIFO: local binary/Gray pointer, remote pointer decode,
// and registered level / full-or-empty / almost / error flags.
module gray_ptr_ctrl
    import cdc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 3,
    parameter bit          IS_WRITE    = 1'b1,
    parameter int unsigned CONV_STAGES = 1,
    parameter int unsigned ALMOST_THR  = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                inc_i,
    input  logic [ADDR_WIDTH:0] remote_gray_i,
    output logic [ADDR_WIDTH:0] ptr_bin_o,
    output logic [ADDR_WIDTH:0] ptr_gray_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                block_o,
    output logic                almost_o,
    output logic [ADDR_WIDTH:0] level_o,
    output logic                err_o
);

    localparam int unsigned PW    = ADDR_WIDTH + 1;
    localparam int unsigned Depth = 1 << ADDR_WIDTH;
    localparam ptr_side_e   Side  = IS_WRITE ? SIDE_WR : SIDE_RD;
    localparam logic BlockRst     = (Side == SIDE_RD);
    localparam logic AlmostRst    = (Side == SIDE_RD) ? 1'b1 : (Depth <= ALMOST_THR);

    if (CONV_STAGES > MAX_CONV_STAGES) begin : g_chk_stages
        $error("gray_ptr_ctrl: CONV_STAGES must be 0..2");
    end
    if (ADDR_WIDTH < 1) begin : g_chk_aw
        $error("gray_ptr_ctrl: ADDR_WIDTH must be at least 1");
    end
    if (ALMOST_THR > Depth) begin : g_chk_thr
        $error("gray_ptr_ctrl: ALMOST_THR exceeds FIFO depth");
    end

    logic [PW-1:0] bin_d, bin_q;
    logic [PW-1:0] gray_d, gray_q;
    logic [PW-1:0] level_d, level_q;
    logic          block_d, block_q;
    logic          almost_d, almost_q;
    logic          err_d, err_q;
    logic          accept;
    logic          bad;
    logic [PW-1:0] remote_bin;
    logic [PW-1:0] raw;
    logic [31:0]   raw_w;

    gray2bin_pipe #(
        .DATA_WIDTH (PW),
        .STAGES     (CONV_STAGES)
    ) u_remote_conv (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .gray_i (remote_gray_i),
        .bin_o  (remote_bin)
    );

    // Flags are computed from the post-accept pointer so they never lag the local side.
    always_comb begin
        accept = inc_i && !block_q;
        bin_d  = bin_q + PW'(accept);
        gray_d = PW'(bin2gray(CDC_MAX_WIDTH'(bin_d)));
        raw    = (Side == SIDE_WR) ? (bin_d - remote_bin) : (remote_bin - bin_d);
        raw_w  = 32'(raw);
        bad    = raw_w > Depth;
        err_d  = (inc_i && block_q) || bad;

        if (bad) begin
            block_d  = 1'b1;
            almost_d = 1'b1;
            level_d  = (Side == SIDE_WR) ? PW'(Depth) : '0;
        end else if (Side == SIDE_WR) begin
            block_d  = (raw_w == Depth);
            almost_d = ((Depth - raw_w) <= ALMOST_THR);
            level_d  = raw;
        end else begin
            block_d  = (raw_w == 32'd0);
            almost_d = (raw_w <= ALMOST_THR);
            level_d  = raw;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bin_q    <= '0;
            gray_q   <= '0;
            level_q  <= '0;
            block_q  <= BlockRst;
            almost_q <= AlmostRst;
            err_q    <= 1'b0;
        end else begin
            bin_q    <= bin_d;
            gray_q   <= gray_d;
            level_q  <= level_d;
            block_q  <= block_d;
            almost_q <= almost_d;
            err_q    <= err_d;
        end
    end

    assign ptr_bin_o  = bin_q;
    assign ptr_gray_o = gray_q;
    assign addr_o     = bin_q[ADDR_WIDTH-1:0];
    assign block_o    = block_q;
    assign almost_o   = almost_q;
    assign level_o    = level_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_gray_ptr_ctrl.sv
// Scoreboard bench: a read-side (2 conv stages) and a write-side (1 conv stage) instance
// driven together and checked against an arithmetic FIFO-occupancy model.
module tb_gray_ptr_ctrl;

    typedef struct {
        logic [3:0] bin;
        logic [3:0] gray;
        logic [2:0] addr;
        logic       blk;
        logic       alm;
        logic [3:0] lvl;
        logic       err;
    } exp_t;

    // Index 0 = read side, 1 = write side.
    localparam int Stg[2] = '{2, 1};
    localparam int Thr[2] = '{1, 2};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inc_s[2];
    logic [3:0] rg_s[2];
    logic [3:0] bin_s[2];
    logic [3:0] gray_s[2];
    logic [2:0] addr_s[2];
    logic       blk_s[2];
    logic       alm_s[2];
    logic [3:0] lvl_s[2];
    logic       err_s[2];

    int checks = 0;
    int errors = 0;

    int   loc[2];
    bit   mblk[2];
    int   rq_rd[$];
    int   rq_wr[$];
    exp_t sb_rd[$];
    exp_t sb_wr[$];

    always #5 clk = ~clk;

    gray_ptr_ctrl #(
        .ADDR_WIDTH(3), .IS_WRITE(1'b0), .CONV_STAGES(2), .ALMOST_THR(1)
    ) u_rd (
        .clk_i(clk), .rst_ni(rst_n), .inc_i(inc_s[0]), .remote_gray_i(rg_s[0]),
        .ptr_bin_o(bin_s[0]), .ptr_gray_o(gray_s[0]), .addr_o(addr_s[0]),
        .block_o(blk_s[0]), .almost_o(alm_s[0]), .level_o(lvl_s[0]), .err_o(err_s[0])
    );

    gray_ptr_ctrl #(
        .ADDR_WIDTH(3), .IS_WRITE(1'b1), .CONV_STAGES(1), .ALMOST_THR(2)
    ) u_wr (
        .clk_i(clk), .rst_ni(rst_n), .inc_i(inc_s[1]), .remote_gray_i(rg_s[1]),
        .ptr_bin_o(bin_s[1]), .ptr_gray_o(gray_s[1]), .addr_o(addr_s[1]),
        .block_o(blk_s[1]), .almost_o(alm_s[1]), .level_o(lvl_s[1]), .err_o(err_s[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Decode by searching for the code word rather than by XOR-prefix.
    function automatic int g2b(input int g);
        for (int n = 0; n < 16; n++) begin
            if (((n ^ (n >> 1)) & 15) == g) return n;
        end
        return 0;
    endfunction

    task automatic model_reset();
        loc[0] = 0; loc[1] = 0;
        mblk[0] = 1'b1; mblk[1] = 1'b0;
        rq_rd.delete(); rq_wr.delete();
        sb_rd.delete(); sb_wr.delete();
        for (int i = 0; i < Stg[0]; i++) rq_rd.push_back(0);
        for (int i = 0; i < Stg[1]; i++) rq_wr.push_back(0);
    endtask

    task automatic model_step(input int s, input bit inc_v, input int rg_v);
        int   rb, raw;
        bit   acc, bad;
        exp_t e;
        if (s == 0) begin
            rq_rd.push_back(g2b(rg_v)); rb = rq_rd.pop_front();
        end else begin
            rq_wr.push_back(g2b(rg_v)); rb = rq_wr.pop_front();
        end
        acc    = inc_v && !mblk[s];
        loc[s] = (loc[s] + int'(acc)) % 16;
        raw    = (s == 1) ? (loc[s] - rb + 16) % 16 : (rb - loc[s] + 16) % 16;
        bad    = raw > 8;
        e.err  = (inc_v && mblk[s]) || bad;
        if (bad) begin
            e.blk = 1'b1; e.alm = 1'b1; e.lvl = (s == 1) ? 4'd8 : 4'd0;
        end else begin
            e.lvl = 4'(raw);
            e.blk = (s == 1) ? (raw == 8) : (raw == 0);
            e.alm = (s == 1) ? ((8 - raw) <= Thr[s]) : (raw <= Thr[s]);
        end
        mblk[s] = e.blk;
        e.bin   = 4'(loc[s]);
        e.gray  = 4'(loc[s] ^ (loc[s] >> 1));
        e.addr  = 3'(loc[s] % 8);
        if (s == 0) sb_rd.push_back(e); else sb_wr.push_back(e);
    endtask

    task automatic compare(input int s, input exp_t e);
        string p;
        p = (s == 0) ? "rd" : "wr";
        chk({p, ".ptr_bin"}, 32'(bin_s[s]), 32'(e.bin));
        chk({p, ".ptr_gray"}, 32'(gray_s[s]), 32'(e.gray));
        chk({p, ".addr"}, 32'(addr_s[s]), 32'(e.addr));
        chk({p, ".block"}, 32'(blk_s[s]), 32'(e.blk));
        chk({p, ".almost"}, 32'(alm_s[s]), 32'(e.alm));
        chk({p, ".level"}, 32'(lvl_s[s]), 32'(e.lvl));
        chk({p, ".err"}, 32'(err_s[s]), 32'(e.err));
    endtask

    task automatic check_reset_vals();
        exp_t r;
        r.bin = '0; r.gray = '0; r.addr = '0; r.lvl = '0; r.err = 1'b0;
        r.blk = 1'b1; r.alm = 1'b1;
        compare(0, r);
        r.blk = 1'b0; r.alm = 1'b0;
        compare(1, r);
    endtask

    // Monitor: outputs are presented every cycle; pop one expectation per side on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check_reset_vals();
        end else begin
            if (sb_rd.size() > 0) compare(0, sb_rd.pop_front());
            if (sb_wr.size() > 0) compare(1, sb_wr.pop_front());
        end
    end

    task automatic drive(input int s, input bit i, input int rbin);
        inc_s[s] = i;
        rg_s[s]  = 4'((rbin ^ (rbin >> 1)) & 15);
    endtask

    // Step the model for the edge just taken, then apply the next inputs.
    task automatic cycle(input bit i0, input int r0, input bit i1, input int r1);
        @(posedge clk);
        #1;
        if (rst_n) begin
            model_step(0, inc_s[0], int'(rg_s[0]));
            model_step(1, inc_s[1], int'(rg_s[1]));
        end
        drive(0, i0, r0);
        drive(1, i1, r1);
    endtask

    task automatic rand_cycle();
        int r0, r1;
        r0 = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 15))
                                          : (loc[0] + int'($urandom_range(0, 8))) % 16;
        r1 = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 15))
                                          : (loc[1] + 16 - int'($urandom_range(0, 8))) % 16;
        cycle($urandom_range(0, 3) != 0, r0, $urandom_range(0, 3) != 0, r1);
    endtask

    initial begin
        drive(0, 1'b0, 0);
        drive(1, 1'b0, 0);
        model_reset();
        #12 rst_n = 1'b1;

        // Fill the write side against remote 0; read side sees 5 words arrive after 3 edges.
        drive(0, 1'b1, 5);
        drive(1, 1'b1, 0);
        for (int k = 0; k < 12; k++) cycle(1'b1, 5, 1'b1, 0);

        // Almost-full region then remote advance to 2 on the write side.
        for (int k = 0; k < 4; k++) cycle(1'b0, 5, 1'b0, 2);

        // Remote tracking the local pointer across the wrap on both sides.
        for (int k = 0; k < 24; k++) cycle(1'b1, (loc[0] + 3) % 16, 1'b1, (loc[1] + 14) % 16);

        // Remote jumps: write side full at raw 8, legal at raw 7, then inconsistent.
        for (int k = 0; k < 3; k++) cycle(1'b0, loc[0], 1'b0, (loc[1] + 8) % 16);
        for (int k = 0; k < 3; k++) cycle(1'b1, loc[0], 1'b1, (loc[1] + 9) % 16);
        for (int k = 0; k < 3; k++) cycle(1'b1, (loc[0] + 13) % 16, 1'b1, (loc[1] + 3) % 16);

        for (int k = 0; k < 300; k++) rand_cycle();

        // Asynchronous reset mid-burst with a non-zero remote held across it.
        for (int k = 0; k < 4; k++) cycle(1'b1, (loc[0] + 6) % 16, 1'b1, (loc[1] + 12) % 16);
        #2 rst_n = 1'b0;
        sb_rd.delete();
        sb_wr.delete();
        #1 check_reset_vals();
        @(posedge clk);
        #4 rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 6; k++) cycle(1'b0, int'(rg_s[0]) == 0 ? 0 : g2b(int'(rg_s[0])),
                                          1'b0, g2b(int'(rg_s[1])));

        for (int k = 0; k < 150; k++) rand_cycle();

        @(negedge clk);
        #1;
        chk("scoreboard_rd_drained", 32'(sb_rd.size()), 32'd0);
        chk("scoreboard_wr_drained", 32'(sb_wr.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
